// File: rtl/d_ff_pipe.sv
// WIDTH-bit, DEPTH-stage register pipeline with per-stage valid bits, stall and flush.
// Optional occupancy counter compiled in with PIPE_OCCUPANCY_EN.
module d_ff_pipe #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         asyncReset,
  input  logic                         en,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             D,
  input  logic                         D_valid,
  output logic [WIDTH-1:0]             Q,
  output logic                         Q_valid
`ifdef PIPE_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`endif
);

  logic [WIDTH-1:0] data_q  [DEPTH];
  logic             valid_q [DEPTH];

  always_ff @(posedge clk or negedge asyncReset) begin
    if (!asyncReset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]  <= RESET_VAL;
        valid_q[i] <= 1'b0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]  <= RESET_VAL;
        valid_q[i] <= 1'b0;
      end
    end else if (en) begin
      data_q[0]  <= D;
      valid_q[0] <= D_valid;
      // Invalid slots shift too; consumers qualify Q with Q_valid.
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i]  <= data_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  assign Q       = data_q[DEPTH-1];
  assign Q_valid = valid_q[DEPTH-1];

`ifdef PIPE_OCCUPANCY_EN
  localparam int unsigned OccW = $clog2(DEPTH+1);

  logic [OccW-1:0] occ_q, occ_d;

  // Modular add/subtract: any transient wrap cancels since the result is <= DEPTH.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (en) begin
      occ_d = occ_q + OccW'(D_valid) - OccW'(valid_q[DEPTH-1]);
    end
  end

  always_ff @(posedge clk or negedge asyncReset) begin
    if (!asyncReset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_d_ff_pipe.sv
// Self-checking bench for d_ff_pipe: history-queue reference model plus directed literal checks.
// Two instances: WIDTH=8/DEPTH=4/RESET_VAL=A5 and WIDTH=1/DEPTH=1.
module tb_d_ff_pipe;

  logic       clk = 1'b0;
  logic       asyncReset;
  logic       en, flush;
  logic [7:0] D;
  logic       D_valid;
  logic [7:0] Q;
  logic       Q_valid;
  logic       D1, D1_valid, Q1, Q1_valid;
`ifdef PIPE_OCCUPANCY_EN
  logic [2:0] occ;
  logic [0:0] occ1;
`endif

  int total = 0;
  int bad   = 0;
  bit run   = 1'b0;

  always #5 clk = ~clk;

  d_ff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) dut (
    .clk       (clk),
    .asyncReset(asyncReset),
    .en        (en),
    .flush     (flush),
    .D         (D),
    .D_valid   (D_valid),
    .Q         (Q),
    .Q_valid   (Q_valid)
`ifdef PIPE_OCCUPANCY_EN
    ,
    .occupancy (occ)
`endif
  );

  d_ff_pipe #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) dut1 (
    .clk       (clk),
    .asyncReset(asyncReset),
    .en        (en),
    .flush     (flush),
    .D         (D1),
    .D_valid   (D1_valid),
    .Q         (Q1),
    .Q_valid   (Q1_valid)
`ifdef PIPE_OCCUPANCY_EN
    ,
    .occupancy (occ1)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // Model: the last DEPTH accepted {valid,data} samples since reset/flush.
  // Q is the oldest of them once DEPTH have been accepted; before that, the reset value.
  logic [8:0] hist [$];
  logic [1:0] hist1 [$];

  always @(posedge clk or negedge asyncReset) begin
    if (!asyncReset) begin
      hist.delete();
      hist1.delete();
    end else if (flush) begin
      hist.delete();
      hist1.delete();
    end else if (en) begin
      hist.push_back({D_valid, D});
      if (hist.size() > 4) void'(hist.pop_front());
      hist1.push_back({D1_valid, D1});
      if (hist1.size() > 1) void'(hist1.pop_front());
    end
  end

  logic [7:0] eq;
  logic       ev, eq1, ev1;
  int         cnt, cnt1;

  always @(negedge clk) begin
    if (run) begin
      eq = 8'hA5; ev = 1'b0; cnt = 0;
      if (hist.size() == 4) begin
        eq = hist[0][7:0];
        ev = hist[0][8];
      end
      foreach (hist[i]) cnt += int'(hist[i][8]);
      eq1 = 1'b0; ev1 = 1'b0; cnt1 = 0;
      if (hist1.size() == 1) begin
        eq1  = hist1[0][0];
        ev1  = hist1[0][1];
        cnt1 = int'(hist1[0][1]);
      end
      if (ev) chk("model_q", int'(Q), int'(eq));
      chk("model_q_valid", int'(Q_valid), int'(ev));
      if (ev1) chk("model_q1", int'(Q1), int'(eq1));
      chk("model_q1_valid", int'(Q1_valid), int'(ev1));
`ifdef PIPE_OCCUPANCY_EN
      chk("model_occ", int'(occ), cnt);
      chk("model_occ1", int'(occ1), cnt1);
`endif
    end
  end

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic e, input logic f, input logic [7:0] d, input logic dv,
                      input logic d1, input logic dv1);
    en = e; flush = f; D = d; D_valid = dv; D1 = d1; D1_valid = dv1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rst_pulse();
    #2 asyncReset = 1'b0;
    #1;
    chk("rst_q", int'(Q), 8'hA5);
    chk("rst_q_valid", int'(Q_valid), 0);
    chk("rst_q1_valid", int'(Q1_valid), 0);
    #1 asyncReset = 1'b1;
  endtask

  int exp_occ [9] = '{1, 2, 3, 4, 3, 2, 1, 0, 0};

  initial begin
    asyncReset = 1'b1;
    en = 1'b0; flush = 1'b0; D = '0; D_valid = 1'b0; D1 = 1'b0; D1_valid = 1'b0;
    // Reset asserted between edges must act without a clock.
    #2 asyncReset = 1'b0;
    #1;
    chk("por_q", int'(Q), 8'hA5);
    chk("por_q_valid", int'(Q_valid), 0);
`ifdef PIPE_OCCUPANCY_EN
    chk("por_occ", int'(occ), 0);
`endif
    run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    asyncReset = 1'b1;

    // First edge after release is a normal edge.
    step(1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 1'b1);
    chk("first_q1", int'(Q1), 1);
    chk("first_q1_valid", int'(Q1_valid), 1);
`ifdef PIPE_OCCUPANCY_EN
    chk("first_occ", int'(occ), 1);
`endif
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("first_q", int'(Q), 8'h01);
    chk("first_q_valid", int'(Q_valid), 1);

    // Latency and throughput, then drain.
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b0, (i < 4) ? 8'(8'h10 + i) : 8'h00, i < 4, i[0], 1'b1);
`ifdef PIPE_OCCUPANCY_EN
      chk("lat_occ", int'(occ), exp_occ[i]);
`endif
      if (i >= 3 && i <= 6) begin
        chk("lat_q", int'(Q), 8'h10 + i - 3);
        chk("lat_q_valid", int'(Q_valid), 1);
      end else if (i == 7) begin
        chk("lat_drained", int'(Q_valid), 0);
      end
    end

    // Stall: two samples in, en low for three cycles.
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h21, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'h77, 1'b1, 1'b1, 1'b1);
      chk("stall_q_valid", int'(Q_valid), 0);
      chk("stall_q", int'(Q), 8'hA5);
`ifdef PIPE_OCCUPANCY_EN
      chk("stall_occ", int'(occ), 2);
`endif
    end
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("resume_q0", int'(Q), 8'h20);
    chk("resume_v0", int'(Q_valid), 1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("resume_q1", int'(Q), 8'h21);
    chk("resume_v1", int'(Q_valid), 1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("resume_end", int'(Q_valid), 0);

    // Flush beats en on the same edge; the FF sample is discarded.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h30 + i), 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1);
    chk("flush_q", int'(Q), 8'hA5);
    chk("flush_q_valid", int'(Q_valid), 0);
    chk("flush_q1_valid", int'(Q1_valid), 0);
`ifdef PIPE_OCCUPANCY_EN
    chk("flush_occ", int'(occ), 0);
`endif
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("flush_no_ff", int'(Q_valid), 0);
    end

    // Bubbles: alternating valid.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 8'($urandom), ~i[0], 1'($urandom), ~i[0]);
      if (i >= 3) chk("bubble_q_valid", int'(Q_valid), i[0] ? 1 : 0);
`ifdef PIPE_OCCUPANCY_EN
      if (i >= 3) chk("bubble_occ", int'(occ), 2);
`endif
    end
    rst_pulse();

    // Randomized traffic with occasional flush and async reset.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, ($urandom % 16) == 0, 8'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom));
      if (($urandom % 50) == 0) rst_pulse();
    end

    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
